// File: rtl/memdump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memdump_pkg
//  Description : Shared types and constants for the data-memory dump
//                controller. The CLEAR state exists only when
//                MEMDUMP_CLEAR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package memdump_pkg;

    localparam int BYTES_PER_WORD   = 4;
    localparam int BYTE_IDX_W       = $clog2(BYTES_PER_WORD);
    localparam int WORD_BYTES_SHIFT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        SEND  = 2'd2
`ifdef MEMDUMP_CLEAR_EN
        ,
        CLEAR = 2'd3
`endif
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_dump_ctrl_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : word_serializer
//  Description : Holds one 32-bit word and presents it LSB byte first on a
//                valid/ready byte stream. Reports the handshake of the final
//                byte so the controller can move to the next word.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_serializer
    import memdump_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        send_en,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        last_byte_accepted
);

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [31:0]           r_word;
    logic [BYTE_IDX_W-1:0] r_byte_cnt;
    logic                  w_hs;

    // Data and valid come straight from held state, so they stay stable
    // until the transmitter takes the byte.
    assign tx_valid           = send_en;
    assign w_hs               = send_en && tx_ready;
    assign tx_data            = r_word[{r_byte_cnt, 3'b000} +: 8];
    assign last_byte_accepted = w_hs && (r_byte_cnt == LAST_BYTE);

    // Capture a fresh word on load, otherwise advance one byte per handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= 32'h0;
            r_byte_cnt <= '0;
        end else if (load) begin
            r_word     <= load_data;
            r_byte_cnt <= '0;
        end else if (w_hs && (r_byte_cnt != LAST_BYTE)) begin
            r_byte_cnt <= r_byte_cnt + BYTE_IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_dump_ctrl
//  Description : Reads WORDS consecutive words from data memory starting at
//                BASE_ADDR and streams each as 4 bytes (LSB first) toward
//                the UART transmitter. Owns the memory port while busy.
//                Optional macro MEMDUMP_CLEAR_EN: zero each word in memory
//                after its last byte has been sent.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_dump_ctrl
    import memdump_pkg::*;
#(
    parameter int          WORDS     = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] readData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int            AW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_word_done;
    logic [31:0]   r_addr_hold;
    logic [31:0]   w_cur_addr;
    logic          w_last_acc;

    // Byte address of the word being handled; wraps naturally at 2^32.
    assign w_cur_addr = BASE_ADDR + (32'(r_idx) << WORD_BYTES_SHIFT);

    // The address shows the live word address during READ and otherwise
    // keeps the last one issued (which is also the CLEAR target).
    assign address   = (r_state == READ) ? w_cur_addr : r_addr_hold;
    assign MemRead   = (r_state == READ);
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign writeData = 32'h0;
`ifdef MEMDUMP_CLEAR_EN
    assign MemWrite  = (r_state == CLEAR);
`else
    assign MemWrite  = 1'b0;
`endif

    word_serializer u_ser (
        .clk                (clk),
        .rst_n              (rst_n),
        .load               (r_state == READ),
        .load_data          (readData),
        .send_en            (r_state == SEND),
        .tx_ready           (tx_ready),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .last_byte_accepted (w_last_acc)
    );

    // Next-state logic: a finished word either starts the next READ or ends the dump.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_word_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = READ;
                    w_idx_nxt   = '0;
                end
            end
            READ: w_state_nxt = SEND;
            SEND: begin
                if (w_last_acc) begin
`ifdef MEMDUMP_CLEAR_EN
                    w_state_nxt = CLEAR;
`else
                    w_word_done = 1'b1;
`endif
                end
            end
`ifdef MEMDUMP_CLEAR_EN
            CLEAR: w_word_done = 1'b1;
`endif
            default: w_state_nxt = IDLE;
        endcase
        if (w_word_done) begin
            if (r_idx == LAST_IDX) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end else begin
                w_idx_nxt   = r_idx + AW'(1);
                w_state_nxt = READ;
            end
        end
    end

    // State, word index, done pulse and held address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_done      <= 1'b0;
            r_addr_hold <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            if (r_state == READ) begin
                r_addr_hold <= w_cur_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_dump_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_dump_ctrl
//  Description : Self-checking bench for mem_dump_ctrl with a memory model
//                and an expected byte/address queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dump_ctrl;

    localparam int          WORDS = 12;
    localparam logic [31:0] BASE  = 32'h0;
`ifdef MEMDUMP_CLEAR_EN
    localparam int PER_WORD = 6;
`else
    localparam int PER_WORD = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tx_ready = 1'b1;
    logic        busy, done, MemRead, MemWrite, tx_valid;
    logic [31:0] address, writeData, readData;
    logic [7:0]  tx_data;

    logic        start2 = 1'b0;
    logic        busy2, done2, MemRead2, MemWrite2, tx_valid2;
    logic [31:0] address2, writeData2, readData2;
    logic [7:0]  tx_data2;

    logic [31:0] mem [0:15];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_done = 0, n_bytes = 0, n_reads = 0, n_writes = 0, done_cyc = 0;
    int n_done2 = 0, done2_cyc = 0;
    int t0 = 0;

    logic [7:0]  exp_bytes [$];
    logic [31:0] exp_addr  [$];
    logic [7:0]  rx_bytes  [$];
    logic [31:0] rd_log    [$];
    logic [7:0]  rx2       [$];
    logic [31:0] rd2       [$];

    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h0;
    logic [31:0] last_rd_addr = 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign readData  = mem[address[5:2]];
    assign readData2 = (address2 == 32'hFFFF_FFFC) ? 32'hDEAD_BEEF :
                       (address2 == 32'h0000_0000) ? 32'h0102_0304 : 32'hBAD0_BAD0;

    mem_dump_ctrl #(.WORDS(WORDS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
        .writeData(writeData), .readData(readData), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    mem_dump_ctrl #(.WORDS(2), .BASE_ADDR(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .MemRead(MemRead2), .MemWrite(MemWrite2), .address(address2),
        .writeData(writeData2), .readData(readData2), .tx_data(tx_data2),
        .tx_valid(tx_valid2), .tx_ready(1'b1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic init_mem();
        mem[0] = 32'h1122_3344;
        mem[1] = 32'hA5A5_0001;
        for (int i = 2; i < 16; i++)
            mem[i] = {8'(i * 17), 8'(i * 5 + 3), 8'hC0 ^ 8'(i), 8'(i * 29)};
    endtask

    // Expected stream straight from memory contents: words in order, LSB first.
    task automatic arm();
        exp_bytes.delete();
        exp_addr.delete();
        for (int w = 0; w < WORDS; w++) begin
            exp_addr.push_back(BASE + 32'(4 * w));
            for (int b = 0; b < 4; b++) exp_bytes.push_back(mem[w][8 * b +: 8]);
        end
    endtask

    // Per-cycle compare against the model while out of reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {31'h0, tx_valid}, 32'h1);
                chk("hold_data", {24'h0, tx_data}, {24'h0, prev_data});
            end
            chk("wdata_zero", writeData, 32'h0);
            if (MemRead) begin
                n_reads++;
                rd_log.push_back(address);
                last_rd_addr = address;
                chk("busy_in_read", {31'h0, busy}, 32'h1);
                if (exp_addr.size() == 0) chk("unexpected_read", address, 32'hFFFF_FFFF);
                else chk("read_addr", address, exp_addr.pop_front());
            end
            if (MemWrite) begin
`ifdef MEMDUMP_CLEAR_EN
                n_writes++;
                chk("clear_addr", address, last_rd_addr);
                mem[address[5:2]] = 32'h0;
`else
                chk("unexpected_write", 32'h1, 32'h0);
`endif
            end
            if (tx_valid && tx_ready) begin
                n_bytes++;
                rx_bytes.push_back(tx_data);
                chk("busy_in_send", {31'h0, busy}, 32'h1);
                if (exp_bytes.size() == 0) chk("extra_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else chk("byte", {24'h0, tx_data}, {24'h0, exp_bytes.pop_front()});
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("done_all_sent", exp_bytes.size(), 32'h0);
                chk("busy_at_done", {31'h0, busy}, 32'h0);
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (MemRead2) rd2.push_back(address2);
            if (tx_valid2) rx2.push_back(tx_data2);
            if (done2) begin
                n_done2++;
                done2_cyc = cyc;
            end
        end
    end

    // mode 0: tx_ready always high; mode 1: high one cycle in three.
    task automatic run_dump(input string tag, input int mode, input int restart_at, input int budget);
        int d0, b0, r0, k;
        arm();
        d0 = n_done; b0 = n_bytes; r0 = n_reads;
        @(posedge clk); #1; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0; t0 = cyc;
        chk({tag, "_busy_after_start"}, {31'h0, busy}, 32'h1);
        k = 0;
        while (n_done == d0 && k < budget) begin
            @(posedge clk); #1;
            k++;
            start    = (k == restart_at);
            tx_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
        end
        start = 1'b0;
        tx_ready = 1'b1;
        if (n_done == d0) chk({tag, "_timeout"}, 32'h0, 32'h1);
        else if (mode == 0) chk({tag, "_done_latency"}, 32'(done_cyc - t0), 32'(PER_WORD * WORDS));
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_nbytes"}, 32'(n_bytes - b0), 32'(4 * WORDS));
        chk({tag, "_nreads"}, 32'(n_reads - r0), 32'(WORDS));
        chk({tag, "_ndone"}, 32'(n_done - d0), 32'h1);
        chk({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        logic [7:0] lit [8];
        int b0, d0, k, orv;
        lit = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h00, 8'hA5, 8'hA5};
        init_mem();

        // Reset state
        #2;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_memread", {31'h0, MemRead}, 32'h0);
        chk("rst_memwrite", {31'h0, MemWrite}, 32'h0);
        chk("rst_addr", address, 32'h0);
        chk("rst_txvalid", {31'h0, tx_valid}, 32'h0);
        chk("rst_txdata", {24'h0, tx_data}, 32'h0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Full dump, ready always high
        rx_bytes.delete(); rd_log.delete();
        run_dump("basic", 0, -1, 200);
        for (int i = 0; i < 8; i++)
            chk("basic_lit_byte", {24'h0, rx_bytes[i]}, {24'h0, lit[i]});
        chk("basic_first_addr", rd_log[0], 32'h0);
        chk("basic_last_addr", rd_log[11], 32'h2C);
`ifdef MEMDUMP_CLEAR_EN
        chk("clear_nwrites", 32'(n_writes), 32'd12);
        rx_bytes.delete();
        run_dump("zero", 0, -1, 200);
        orv = 0;
        foreach (rx_bytes[i]) orv = orv | int'(rx_bytes[i]);
        chk("zero_bytes", 32'(orv), 32'h0);
`endif

        // Throttled transmitter
        init_mem();
        run_dump("stall", 1, -1, 400);

        // Start again while busy
        init_mem();
        run_dump("restart", 0, 10, 200);

        // Asynchronous reset in the middle of a word
        init_mem();
        arm();
        b0 = n_bytes; d0 = n_done;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        k = 0;
        while (n_bytes - b0 < 2 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("abort_reach_byte2", 32'(n_bytes - b0), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_txvalid", {31'h0, tx_valid}, 32'h0);
        chk("abort_txdata", {24'h0, tx_data}, 32'h0);
        chk("abort_addr", address, 32'h0);
        chk("abort_memread", {31'h0, MemRead}, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(n_done - d0), 32'h0);
        init_mem();
        b0 = n_bytes;
        rd_log.delete();
        run_dump("after_abort", 0, -1, 200);
        chk("after_abort_addr0", rd_log[0], BASE);
        chk("after_abort_byte0", {24'h0, rx_bytes[b0]}, {24'h0, mem[0][7:0]});

        // Address wrap with two words
        @(posedge clk); #1; start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0; t0 = cyc;
        k = 0;
        while (n_done2 == 0 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("wrap_done", 32'(n_done2), 32'h1);
        chk("wrap_latency", 32'(done2_cyc - t0), 32'(PER_WORD * 2));
        chk("wrap_nreads", 32'(rd2.size()), 32'd2);
        chk("wrap_nbytes", 32'(rx2.size()), 32'd8);
        if (rd2.size() == 2) begin
            chk("wrap_addr0", rd2[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", rd2[1], 32'h0000_0000);
        end
        if (rx2.size() == 8) begin
            chk("wrap_b0", {24'h0, rx2[0]}, 32'hEF);
            chk("wrap_b3", {24'h0, rx2[3]}, 32'hDE);
            chk("wrap_b4", {24'h0, rx2[4]}, 32'h04);
            chk("wrap_b7", {24'h0, rx2[7]}, 32'h01);
        end
        chk("wrap_wdata", writeData2, 32'h0);
        chk("wrap_idle", {31'h0, busy2}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
